// File: rtl/arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// The FSM state type and the port-select encoding live here so that the
// arbiter and anything observing selectOutput agree on the meaning of 0/1.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Generic 2:1 multiplexer used to steer the fetch or data address into the
// arbiter's capture register. choiceInput = 0 picks firstInput.
module Multiplexer #(
  parameter int n = 32
) (
  input  logic [n-1:0] firstInput,
  input  logic [n-1:0] secondInput,
  input  logic         choiceInput,
  output logic [n-1:0] muxOutput
);

  // Pure combinational select between the two sources.
  always_comb begin
    muxOutput = choiceInput ? secondInput : firstInput;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store. One transaction at a time: IDLE -> BUSY (memReq held until
// ack) -> RESP (one-cycle done pulse) -> IDLE. Data wins ties unless fetch has
// been passed over STARVE_LIMIT times in a row.
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES cycles without ack (done + errorOutput, readData cleared).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int n            = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clockInput,
  input  logic              resetInput,
  input  logic              fetchReqInput,
  input  logic [ADDR_W-1:0] fetchAddrInput,
  output logic              fetchDoneOutput,
  input  logic              dataReqInput,
  input  logic              dataWriteInput,
  input  logic [ADDR_W-1:0] dataAddrInput,
  input  logic [n-1:0]      dataWdataInput,
  output logic              dataDoneOutput,
  output logic [n-1:0]      readDataOutput,
  output logic              memReqOutput,
  output logic              memWriteOutput,
  output logic [ADDR_W-1:0] memAddrOutput,
  output logic [n-1:0]      memWdataOutput,
  input  logic              memAckInput,
  input  logic [n-1:0]      memRdataInput,
  output logic              selectOutput,
  output logic              busyOutput,
  output logic              errorOutput
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state;
  arb_state_t          nextState;
  logic                anyReq;
  logic                grantData;
  logic                nextSel;
  logic                selReg;
  logic                writeReg;
  logic                timeoutHit;
  logic [ADDR_W-1:0]   steeredAddr;
  logic [ADDR_W-1:0]   addrReg;
  logic [n-1:0]        wdataReg;
  logic [n-1:0]        readDataReg;
  logic [STARVE_W-1:0] starveCnt;

  assign anyReq    = fetchReqInput | dataReqInput;
  // Data takes the port unless fetch is waiting and has hit its starvation limit.
  assign grantData = dataReqInput &
                     ~(fetchReqInput & (starveCnt == STARVE_W'(STARVE_LIMIT)));
  // Only IDLE chooses a new owner; elsewhere the current owner keeps the select.
  assign nextSel   = (state == IDLE) ? (grantData ? SEL_DATA : SEL_FETCH) : selReg;

  Multiplexer #(
    .n (ADDR_W)
  ) addrMux (
    .firstInput  (fetchAddrInput),
    .secondInput (dataAddrInput),
    .choiceInput (nextSel),
    .muxOutput   (steeredAddr)
  );

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) state <= IDLE;
    else            state <= nextState;
  end

  // Next-state logic: any request starts a transaction, ack (or abort) ends BUSY.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = BUSY;
      BUSY:    if (memAckInput || timeoutHit) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode: request/write only while BUSY, done pulses go to the owner in RESP.
  always_comb begin
    memReqOutput    = 1'b0;
    memWriteOutput  = 1'b0;
    fetchDoneOutput = 1'b0;
    dataDoneOutput  = 1'b0;
    busyOutput      = (state != IDLE);
    if (state == BUSY) begin
      memReqOutput   = 1'b1;
      memWriteOutput = writeReg;
    end
    if (state == RESP) begin
      fetchDoneOutput = (selReg == SEL_FETCH);
      dataDoneOutput  = (selReg == SEL_DATA);
    end
  end

  // Grant edge: capture owner, address, write data and direction so requesters may move on.
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) begin
      selReg   <= SEL_FETCH;
      addrReg  <= '0;
      wdataReg <= '0;
      writeReg <= 1'b0;
    end else if (state == IDLE && anyReq) begin
      selReg   <= nextSel;
      addrReg  <= steeredAddr;
      wdataReg <= grantData ? dataWdataInput : '0;
      writeReg <= grantData & dataWriteInput;
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) begin
      starveCnt <= '0;
    end else if (state == IDLE && anyReq) begin
      if (!grantData)         starveCnt <= '0;
      else if (fetchReqInput) starveCnt <= starveCnt + 1'b1;
    end
  end

  // Read data register: loads and fetches latch memory data on ack; aborts clear it.
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) begin
      readDataReg <= '0;
    end else if (state == BUSY) begin
      if (memAckInput) begin
        if (!writeReg) readDataReg <= memRdataInput;
      end else if (timeoutHit) begin
        readDataReg <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMEOUT_W-1:0] timeoutCnt;
  logic                 errorReg;

  // Timeout counter: counts cycles spent in BUSY, restarts for every transaction.
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput)          timeoutCnt <= '0;
    else if (state == BUSY)  timeoutCnt <= timeoutCnt + 1'b1;
    else                     timeoutCnt <= '0;
  end

  assign timeoutHit = (state == BUSY) && !memAckInput &&
                      (timeoutCnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  // Error flag: high exactly during the RESP cycle that follows an abort.
  always_ff @(posedge clockInput or posedge resetInput) begin
    if (resetInput) errorReg <= 1'b0;
    else            errorReg <= timeoutHit;
  end

  assign errorOutput = errorReg;
`else
  assign timeoutHit  = 1'b0;
  assign errorOutput = 1'b0;
`endif

  assign memAddrOutput  = addrReg;
  assign memWdataOutput = wdataReg;
  assign readDataOutput = readDataReg;
  assign selectOutput   = selReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Expected grants, captured values,
// done pulses and read data come from a transaction-level model of the
// arbitration rules (tie-break, starvation count, read-data retention).
module tb_mem_port_arbiter;

  localparam int N  = 32;
  localparam int AW = 32;
  localparam int SL = 4;

  logic          clockInput = 1'b0;
  logic          resetInput;
  logic          fetchReqInput;
  logic [AW-1:0] fetchAddrInput;
  logic          fetchDoneOutput;
  logic          dataReqInput;
  logic          dataWriteInput;
  logic [AW-1:0] dataAddrInput;
  logic [N-1:0]  dataWdataInput;
  logic          dataDoneOutput;
  logic [N-1:0]  readDataOutput;
  logic          memReqOutput;
  logic          memWriteOutput;
  logic [AW-1:0] memAddrOutput;
  logic [N-1:0]  memWdataOutput;
  logic          memAckInput;
  logic [N-1:0]  memRdataInput;
  logic          selectOutput;
  logic          busyOutput;
  logic          errorOutput;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          starveModel;
  logic [N-1:0] expRead;

  mem_port_arbiter #(
    .n            (N),
    .ADDR_W       (AW),
    .STARVE_LIMIT (SL)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clockInput      (clockInput),
    .resetInput      (resetInput),
    .fetchReqInput   (fetchReqInput),
    .fetchAddrInput  (fetchAddrInput),
    .fetchDoneOutput (fetchDoneOutput),
    .dataReqInput    (dataReqInput),
    .dataWriteInput  (dataWriteInput),
    .dataAddrInput   (dataAddrInput),
    .dataWdataInput  (dataWdataInput),
    .dataDoneOutput  (dataDoneOutput),
    .readDataOutput  (readDataOutput),
    .memReqOutput    (memReqOutput),
    .memWriteOutput  (memWriteOutput),
    .memAddrOutput   (memAddrOutput),
    .memWdataOutput  (memWdataOutput),
    .memAckInput     (memAckInput),
    .memRdataInput   (memRdataInput),
    .selectOutput    (selectOutput),
    .busyOutput      (busyOutput),
    .errorOutput     (errorOutput)
  );

  always #5 clockInput = ~clockInput;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fReq, input logic [AW-1:0] fAddr,
                               input logic dReq, input logic dWrite,
                               input logic [AW-1:0] dAddr, input logic [N-1:0] dWdata);
    fetchReqInput  = fReq;
    fetchAddrInput = fAddr;
    dataReqInput   = dReq;
    dataWriteInput = dWrite;
    dataAddrInput  = dAddr;
    dataWdataInput = dWdata;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".memReq"},    64'(memReqOutput),    64'd0);
    checkOutput({tag, ".memWrite"},  64'(memWriteOutput),  64'd0);
    checkOutput({tag, ".busy"},      64'(busyOutput),      64'd0);
    checkOutput({tag, ".fetchDone"}, 64'(fetchDoneOutput), 64'd0);
    checkOutput({tag, ".dataDone"},  64'(dataDoneOutput),  64'd0);
    checkOutput({tag, ".error"},     64'(errorOutput),     64'd0);
    checkOutput({tag, ".readData"},  64'(readDataOutput),  64'(expRead));
  endtask

  // One full transaction starting in IDLE with requests already applied.
  task automatic runTransaction(input string tag, input int waits, input logic [N-1:0] rdata,
                                output logic grantedData, output int writeCycles);
    logic          expData;
    logic          expWr;
    logic [AW-1:0] expAddr;
    logic [N-1:0]  expWd;
    expData = dataReqInput && !(fetchReqInput && starveModel == SL);
    if (!expData)           starveModel = 0;
    else if (fetchReqInput) starveModel = starveModel + 1;
    expAddr = expData ? dataAddrInput : fetchAddrInput;
    expWr   = expData && dataWriteInput;
    expWd   = dataWdataInput;
    writeCycles = 0;
    @(posedge clockInput); #1;
    // Owner inputs are free to change once granted
    if (expData) begin
      dataAddrInput  = $urandom;
      dataWdataInput = $urandom;
      dataWriteInput = $urandom_range(0, 1);
    end else begin
      fetchAddrInput = $urandom;
    end
    checkOutput({tag, ".select"}, 64'(selectOutput), 64'(expData));
    if (expWr) checkOutput({tag, ".memWdata"}, 64'(memWdataOutput), 64'(expWd));
    for (int c = 0; c <= waits; c++) begin
      checkOutput({tag, ".memReq"},   64'(memReqOutput),   64'd1);
      checkOutput({tag, ".memWrite"}, 64'(memWriteOutput), 64'(expWr));
      checkOutput({tag, ".memAddr"},  64'(memAddrOutput),  64'(expAddr));
      checkOutput({tag, ".busy"},     64'(busyOutput),     64'd1);
      if (memWriteOutput === 1'b1) writeCycles++;
      memAckInput   = (c == waits);
      memRdataInput = (c == waits) ? rdata : N'($urandom);
      @(posedge clockInput); #1;
    end
    memAckInput = 1'b0;
    if (!expWr) expRead = rdata;
    checkOutput({tag, ".fetchDone"}, 64'(fetchDoneOutput), 64'(!expData));
    checkOutput({tag, ".dataDone"},  64'(dataDoneOutput),  64'(expData));
    checkOutput({tag, ".readData"},  64'(readDataOutput),  64'(expRead));
    checkOutput({tag, ".respReq"},   64'(memReqOutput),    64'd0);
    checkOutput({tag, ".respErr"},   64'(errorOutput),     64'd0);
    if (expData) dataReqInput = 1'b0;
    else         fetchReqInput = 1'b0;
    @(posedge clockInput); #1;
    checkIdleOutputs({tag, ".idle"});
    grantedData = expData;
  endtask

  initial begin
    logic g;
    int   wc;
    logic [N-1:0] savedRead;

    resetInput    = 1'b1;
    memAckInput   = 1'b0;
    memRdataInput = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    starveModel = 0;
    expRead     = '0;
    repeat (2) @(posedge clockInput);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset.select",  64'(selectOutput),  64'd0);
    checkOutput("reset.memAddr", 64'(memAddrOutput), 64'd0);
    resetInput = 1'b0;

    $display("[TB] fetch read with immediate ack");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
    runTransaction("fetch", 0, 32'hDEADBEEF, g, wc);
    checkOutput("fetch.grant", 64'(g), 64'd0);
    checkOutput("fetch.rdata", 64'(readDataOutput), 64'hDEADBEEF);

    $display("[TB] simultaneous fetch and load");
    applyStimulus(1'b1, 32'h140, 1'b1, 1'b0, 32'h180, '0);
    runTransaction("tieLoad", 1, 32'h0BADF00D, g, wc);
    checkOutput("tie.first", 64'(g), 64'd1);
    runTransaction("tieFetch", 0, 32'h11112222, g, wc);
    checkOutput("tie.second", 64'(g), 64'd0);

    $display("[TB] fetch starvation limit");
    fetchReqInput  = 1'b1;
    fetchAddrInput = 32'h1000;
    for (int k = 0; k < SL + 2; k++) begin
      if (!dataReqInput) begin
        dataReqInput   = 1'b1;
        dataWriteInput = $urandom_range(0, 1);
        dataAddrInput  = 32'h2000 + 32'(k * 4);
        dataWdataInput = $urandom;
      end
      runTransaction("starve", $urandom_range(0, 2), $urandom, g, wc);
      checkOutput("starve.order", 64'(g), (k == SL) ? 64'd0 : 64'd1);
    end

    $display("[TB] store with three wait cycles");
    savedRead = readDataOutput;
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'h12345678);
    runTransaction("store", 3, 32'hFFFF0000, g, wc);
    checkOutput("store.writeCycles", 64'(wc), 64'd4);
    checkOutput("store.readKept", 64'(readDataOutput), 64'(savedRead));

    $display("[TB] reset in the middle of BUSY");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h3A0, 32'hCAFE0001);
    @(posedge clockInput); #1;
    checkOutput("midReset.busyBefore", 64'(busyOutput), 64'd1);
    #2 resetInput = 1'b1;
    #1;
    expRead     = '0;
    starveModel = 0;
    checkIdleOutputs("midReset");
    checkOutput("midReset.select",  64'(selectOutput),   64'd0);
    checkOutput("midReset.memAddr", 64'(memAddrOutput),  64'd0);
    checkOutput("midReset.wdata",   64'(memWdataOutput), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge clockInput); #1;
    resetInput = 1'b0;
    @(posedge clockInput); #1;
    memAckInput   = 1'b1;
    memRdataInput = 32'h55AA55AA;
    @(posedge clockInput); #1;
    memAckInput = 1'b0;
    checkIdleOutputs("staleAck");
    @(posedge clockInput); #1;
    checkIdleOutputs("staleAck2");

    $display("[TB] randomized traffic");
    for (int t = 0; t < 30; t++) begin
      if (!fetchReqInput && $urandom_range(0, 1) == 1) begin
        fetchReqInput  = 1'b1;
        fetchAddrInput = 32'h4000 + 32'($urandom_range(0, 63) * 4);
      end
      if (!dataReqInput && ($urandom_range(0, 1) == 1 || !fetchReqInput)) begin
        dataReqInput   = 1'b1;
        dataWriteInput = $urandom_range(0, 1);
        dataAddrInput  = 32'h8000 + 32'($urandom_range(0, 63) * 4);
        dataWdataInput = $urandom;
      end
      runTransaction("random", $urandom_range(0, 3), $urandom, g, wc);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(posedge clockInput); #1;

`ifdef ARB_TIMEOUT_EN
    $display("[TB] timeout abort");
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, '0, '0);
    starveModel = 0;
    @(posedge clockInput); #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("timeout.memReq", 64'(memReqOutput), 64'd1);
      @(posedge clockInput); #1;
    end
    expRead = '0;
    checkOutput("timeout.dropReq",  64'(memReqOutput),    64'd0);
    checkOutput("timeout.done",     64'(fetchDoneOutput), 64'd1);
    checkOutput("timeout.error",    64'(errorOutput),     64'd1);
    checkOutput("timeout.readData", 64'(readDataOutput),  64'd0);
    fetchReqInput = 1'b0;
    @(posedge clockInput); #1;
    checkIdleOutputs("timeout.idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
